alarm_persist: RTL and testbench
================================

Name: alarm_persist

Overview:
- Per-bit persistence filter upstream of the sticky-alarm latch.
- Turns raw per-cycle defect indications into declared/cleared alarm states using programmable consecutive-sample thresholds.
- `alarm` drives the sticky block's alarm input directly. `alarm_chg` is available for change-event stickies.
- Sampling is paced by an external `tick` strobe, e.g. the 1 ms or frame strobe.

Parameters:
- WIDTH, 8, number of independent alarm bits.
- CWIDTH, 4, width of each persistence counter and of each threshold.

Ports:
- clk  input  1  system clock.
- rst_  input  1  asynchronous active-low reset.
- upactive  input  1  block enable; low forces every bit to the cleared idle state.
- tick  input  1  sample strobe; `defect` is evaluated only in cycles where `tick` = 1.
- defect  input  WIDTH  raw defect indications, one per bit.
- set_thr  input  CWIDTH  consecutive defect ticks required to declare an alarm; shared by all bits.
- clr_thr  input  CWIDTH  consecutive clean ticks required to clear an alarm; shared by all bits.
- alarm  output  WIDTH  filtered alarm state, registered.
- alarm_chg  output  WIDTH  one-cycle pulse on any `alarm` transition, registered.

Behaviour:
- Reset (`rst_` low, asynchronous): all counters = 0, `alarm` = 0, `alarm_chg` = 0.
- Per-bit state: `alarm[i]` (0 = clear, 1 = declared) plus counter `cnt[i]`. Bits are fully independent.
- Effective thresholds: `set_eff` = max(`set_thr`, 1) and `clr_eff` = max(`clr_thr`, 1). A value of 0 behaves as 1.
- When `upactive` = 0 (synchronous, takes priority over `tick`): `cnt` <= 0, `alarm` <= 0, `alarm_chg` <= 0.
  - Forcing `alarm` low here is not reported as a change.
- When `upactive` = 1 and `tick` = 0: `cnt` and `alarm` hold, and `alarm_chg` <= 0.
- When `upactive` = 1, `tick` = 1 and `alarm[i]` = 0:
  - If `defect[i]` = 1 and `cnt` + 1 >= `set_eff`: `alarm[i]` <= 1, `cnt` <= 0, `alarm_chg[i]` <= 1.
  - If `defect[i]` = 1 otherwise: `cnt` <= `cnt` + 1, saturating at 2^CWIDTH − 1.
  - If `defect[i]` = 0: `cnt` <= 0, so consecutive counting restarts.
- When `upactive` = 1, `tick` = 1 and `alarm[i]` = 1: mirror image of the clear case.
  - Count ticks with `defect[i]` = 0 against `clr_eff`.
  - On reaching the threshold: `alarm[i]` <= 0, `cnt` <= 0, `alarm_chg[i]` <= 1.
  - A tick with `defect[i]` = 1 resets `cnt` to 0.
- `alarm_chg[i]` is high for exactly the one clk cycle after the edge at which `alarm[i]` changed. Otherwise it is 0.
- Latency: `alarm` updates at the clk edge of the tick that satisfies the threshold. With `set_thr` = 3, `alarm` is visible one clk after the 3rd consecutive defect tick.
- Counter arithmetic:
  - Compare uses `cnt` + 1 computed at CWIDTH+1 bits, so there is no wrap.
  - Saturation means `cnt` never wraps to 0.
- Threshold change mid-count: the new value applies from the next tick. If `cnt` is already >= the new threshold − 1, the next qualifying tick declares or clears.
- `defect` is sampled only on ticks. A defect pulse between ticks has no effect.
- `tick` held high continuously is legal; every clk then counts as one sample.
- Reset asserted mid-count: immediate return to the reset state. No partial count survives.

Test Plan:
- Reset, then `upactive` = 1, `set_thr` = 3, `clr_thr` = 2, `defect[0]` = 1 on ticks 1–3 -> `alarm[0]` = 0 after ticks 1 and 2, = 1 one clk after tick 3; `alarm_chg[0]` pulses exactly 1 cycle. Other bits stay 0.
- Declared bit 0, `defect[0]` = 0 for 1 tick, 1 for 1 tick, then 0 for 2 ticks -> first clean run is broken, so `alarm[0]` clears only after the final 2nd consecutive clean tick; one `alarm_chg` pulse.
- `set_thr` = 3, defect pattern 1,1,0,1,1,1 over 6 ticks -> `alarm` declares only after tick 6; no `alarm_chg` before.
- `set_thr` = 0 and `set_thr` = 15 (CWIDTH = 4) -> declare after 1 tick and after 15 ticks respectively. Holding `defect` for 40 ticks after declare keeps `cnt` at 0 and `alarm` at 1 (no wrap, no toggle).
- Bit 2 declared, then `upactive` = 0 for 2 cycles with `tick` = 1 -> `alarm[2]` = 0 the next clk, no `alarm_chg`. Re-enabling with `defect[2]` = 1 requires a full `set_thr` ticks to redeclare.
- `rst_` pulsed low asynchronously between clk edges while bit 5 `cnt` = 2 -> `alarm`/`alarm_chg` = 0 immediately. After release, declaring needs a full `set_thr` count.

Source files
------------

// File: rtl/alarm_persist.sv
// alarm_persist: per-bit persistence filter that turns raw defect indications
// into declared/cleared alarm states using consecutive-tick thresholds.
//
// Ports:
//   clk        system clock
//   rst_       asynchronous active-low reset
//   upactive   block enable; low forces all bits to the cleared idle state
//   tick       sample strobe; defect is evaluated only when tick = 1
//   defect     raw per-bit defect indications
//   set_thr    consecutive defect ticks needed to declare (0 behaves as 1)
//   clr_thr    consecutive clean ticks needed to clear (0 behaves as 1)
//   alarm      filtered alarm state (registered)
//   alarm_chg  one-cycle pulse on any alarm transition (registered)
module alarm_persist #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              upactive,
  input  logic              tick,
  input  logic [WIDTH-1:0]  defect,
  input  logic [CWIDTH-1:0] set_thr,
  input  logic [CWIDTH-1:0] clr_thr,
  output logic [WIDTH-1:0]  alarm,
  output logic [WIDTH-1:0]  alarm_chg
);

  localparam logic [CWIDTH-1:0] CNT_MAX = '1;

  logic [CWIDTH-1:0] cnt_q   [WIDTH];
  logic [CWIDTH-1:0] cnt_d   [WIDTH];
  logic [CWIDTH:0]   cnt_p1  [WIDTH];
  logic [CWIDTH:0]   thr_ext [WIDTH];
  logic [WIDTH-1:0]  alarm_d;
  logic [WIDTH-1:0]  chg_d;
  logic [WIDTH-1:0]  hit;
  logic [CWIDTH-1:0] set_eff;
  logic [CWIDTH-1:0] clr_eff;

  // Zero thresholds behave as one.
  always_comb begin
    set_eff = (set_thr == '0) ? CWIDTH'(1) : set_thr;
    clr_eff = (clr_thr == '0) ? CWIDTH'(1) : clr_thr;
  end

  // A sample counts toward a transition when it disagrees with the current state.
  assign hit = defect ^ alarm;

  // Next-state logic for every bit's counter, alarm and change pulse.
  always_comb begin
    alarm_d = alarm;
    chg_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i]   = cnt_q[i];
      // One bit wider than the counter so cnt + 1 never wraps in the compare.
      cnt_p1[i]  = {1'b0, cnt_q[i]} + (CWIDTH+1)'(1);
      thr_ext[i] = {1'b0, (alarm[i] ? clr_eff : set_eff)};
      if (!upactive) begin
        cnt_d[i]   = '0;
        alarm_d[i] = 1'b0;
      end else if (tick) begin
        if (hit[i]) begin
          if (cnt_p1[i] >= thr_ext[i]) begin
            alarm_d[i] = ~alarm[i];
            cnt_d[i]   = '0;
            chg_d[i]   = 1'b1;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_p1[i][CWIDTH-1:0];
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      alarm     <= '0;
      alarm_chg <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      alarm     <= alarm_d;
      alarm_chg <= chg_d;
    end
  end

endmodule

// File: tb/tb_alarm_persist.sv
// Directed testbench for alarm_persist with hand-computed expected values.
module tb_alarm_persist;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CWIDTH = 4;

  logic              clk;
  logic              rst_;
  logic              upactive;
  logic              tick;
  logic [WIDTH-1:0]  defect;
  logic [CWIDTH-1:0] set_thr;
  logic [CWIDTH-1:0] clr_thr;
  logic [WIDTH-1:0]  alarm;
  logic [WIDTH-1:0]  alarm_chg;

  int total = 0;
  int bad   = 0;

  alarm_persist #(.WIDTH(WIDTH), .CWIDTH(CWIDTH)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .upactive  (upactive),
    .tick      (tick),
    .defect    (defect),
    .set_thr   (set_thr),
    .clr_thr   (clr_thr),
    .alarm     (alarm),
    .alarm_chg (alarm_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One sampling clock with tick high, then check alarm and alarm_chg.
  task automatic tk(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ea,
                    input logic [WIDTH-1:0] ec, input string tag);
    defect = d;
    tick   = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk({tag, ".alarm"}, 32'(alarm), 32'(ea));
    chk({tag, ".chg"}, 32'(alarm_chg), 32'(ec));
  endtask

  // One clock with tick low, then check.
  task automatic idle(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ea,
                      input string tag);
    defect = d;
    tick   = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".alarm"}, 32'(alarm), 32'(ea));
    chk({tag, ".chg"}, 32'(alarm_chg), 32'(0));
  endtask

  initial begin
    int pat [6];
    pat = '{1, 1, 0, 1, 1, 1};

    rst_     = 1'b0;
    upactive = 1'b0;
    tick     = 1'b0;
    defect   = '0;
    set_thr  = 4'd3;
    clr_thr  = 4'd2;
    #1;
    chk("reset.alarm", 32'(alarm), 32'(0));
    chk("reset.chg", 32'(alarm_chg), 32'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_     = 1'b1;
    upactive = 1'b1;
    @(posedge clk);
    #1;

    // Declare bit 0 after 3 consecutive defect ticks.
    tk(8'h01, 8'h00, 8'h00, "set1");
    tk(8'h01, 8'h00, 8'h00, "set2");
    tk(8'h01, 8'h01, 8'h01, "set3");
    idle(8'h01, 8'h01, "set_hold");

    // Broken clean run: clears only on the second consecutive clean tick.
    tk(8'h00, 8'h01, 8'h00, "clr1");
    tk(8'h01, 8'h01, 8'h00, "clr_brk");
    tk(8'h00, 8'h01, 8'h00, "clr2");
    tk(8'h00, 8'h00, 8'h01, "clr3");
    idle(8'h00, 8'h00, "clr_hold");

    // Pattern 1,1,0,1,1,1 declares only on tick 6.
    for (int k = 0; k < 6; k++) begin
      tk(pat[k] != 0 ? 8'h01 : 8'h00, k == 5 ? 8'h01 : 8'h00,
         k == 5 ? 8'h01 : 8'h00, $sformatf("pat%0d", k));
    end
    tk(8'h00, 8'h01, 8'h00, "pat_c1");
    tk(8'h00, 8'h00, 8'h01, "pat_c2");

    // Defect pulse between ticks is ignored.
    idle(8'hff, 8'h00, "between");

    // Threshold 0 behaves as 1; then tick held high for 40 cycles.
    set_thr = 4'd0;
    tk(8'h01, 8'h01, 8'h01, "thr0");
    for (int k = 0; k < 40; k++) begin
      tk(8'h01, 8'h01, 8'h00, $sformatf("hold%0d", k));
    end
    tk(8'h00, 8'h01, 8'h00, "thr0_c1");
    tk(8'h00, 8'h00, 8'h01, "thr0_c2");

    // Threshold 15: declares on the 15th consecutive tick.
    set_thr = 4'd15;
    for (int k = 1; k <= 15; k++) begin
      tk(8'h01, k == 15 ? 8'h01 : 8'h00, k == 15 ? 8'h01 : 8'h00,
         $sformatf("thr15_%0d", k));
    end
    tk(8'h00, 8'h01, 8'h00, "thr15_c1");
    tk(8'h00, 8'h00, 8'h01, "thr15_c2");

    // Bit 2 declared, then upactive low clears it silently.
    set_thr = 4'd3;
    tk(8'h04, 8'h00, 8'h00, "b2_1");
    tk(8'h04, 8'h00, 8'h00, "b2_2");
    tk(8'h04, 8'h04, 8'h04, "b2_3");
    upactive = 1'b0;
    tk(8'h04, 8'h00, 8'h00, "down1");
    tk(8'h04, 8'h00, 8'h00, "down2");
    upactive = 1'b1;
    tk(8'h04, 8'h00, 8'h00, "re1");
    tk(8'h04, 8'h00, 8'h00, "re2");
    tk(8'h04, 8'h04, 8'h04, "re3");

    // Bit 5 at cnt=2 with bit 2 declared; async reset between edges.
    tk(8'h24, 8'h04, 8'h00, "b5_1");
    tk(8'h24, 8'h04, 8'h00, "b5_2");
    #3;
    rst_ = 1'b0;
    #1;
    chk("arst.alarm", 32'(alarm), 32'(0));
    chk("arst.chg", 32'(alarm_chg), 32'(0));
    #2;
    rst_ = 1'b1;
    tk(8'h20, 8'h00, 8'h00, "post1");
    tk(8'h20, 8'h00, 8'h00, "post2");
    tk(8'h20, 8'h20, 8'h20, "post3");

    // Threshold lowered mid-count: next qualifying tick declares.
    set_thr = 4'd5;
    tk(8'h22, 8'h20, 8'h00, "mid1");
    tk(8'h22, 8'h20, 8'h00, "mid2");
    tk(8'h22, 8'h20, 8'h00, "mid3");
    set_thr = 4'd2;
    tk(8'h22, 8'h22, 8'h02, "mid4");
    idle(8'h22, 8'h22, "mid_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
